// File: rtl/music_game_pkg.sv
// Shared definitions for the note-length encoding path.
//   - Length codes as stored in the game's note tables, with their beat-unit values.
//   - Quantiser thresholds: counts at or above these snap to the 4- and 12-unit codes.
//   - State type for the note_length_encoder FSM.
package music_game_pkg;

    localparam logic [2:0] LEN_CODE_U2  = 3'd0;
    localparam logic [2:0] LEN_CODE_U1  = 3'd1;
    localparam logic [2:0] LEN_CODE_U3  = 3'd2;
    localparam logic [2:0] LEN_CODE_U4  = 3'd3;
    localparam logic [2:0] LEN_CODE_U12 = 3'd4;

    localparam int unsigned LEN_UNITS_U1  = 1;
    localparam int unsigned LEN_UNITS_U2  = 2;
    localparam int unsigned LEN_UNITS_U3  = 3;
    localparam int unsigned LEN_UNITS_U4  = 4;
    localparam int unsigned LEN_UNITS_U12 = 12;

    // 8 is equidistant from 4 and 12; ties round up to the longer note.
    localparam int unsigned QUANT_THR_U4  = 4;
    localparam int unsigned QUANT_THR_U12 = 8;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StEmit,
        StWaitRel
    } note_state_e;

endpackage

// File: rtl/length_quantizer.sv
// Combinational count-to-length-code quantiser, shared by the note and rest paths.
// Ports:
//   count_i  measured length in beat units
//   code_o   nearest legal length code (0 and 1 units both map to the 1-unit code)
module length_quantizer
    import music_game_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic [CNT_W-1:0] count_i,
    output logic [2:0]       code_o
);

    logic [31:0] count_ext;

    assign count_ext = 32'(count_i);

    always_comb begin
        code_o = LEN_CODE_U1;
        if (count_ext >= QUANT_THR_U12) begin
            code_o = LEN_CODE_U12;
        end else if (count_ext >= QUANT_THR_U4) begin
            code_o = LEN_CODE_U4;
        end else if (count_ext == LEN_UNITS_U3) begin
            code_o = LEN_CODE_U3;
        end else if (count_ext == LEN_UNITS_U2) begin
            code_o = LEN_CODE_U2;
        end
    end

endmodule

// File: rtl/note_length_encoder.sv
// Measures key hold time in beat ticks and emits the quantised 3-bit note length code.
// Optional rest measurement is enabled by defining NOTE_LENGTH_REST_EN.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   beat_tick    one-cycle pulse per length unit
//   key_in       debounced key level, 1 = pressed
//   length_code  last emitted code, held between emissions
//   code_valid   one-cycle pulse when length_code is updated
//   overflow     with code_valid: the measurement hit MAX_UNITS
//   note_active  a press is being measured
//   is_rest      last emitted code describes a rest (0 when rests are disabled)
module note_length_encoder
    import music_game_pkg::*;
#(
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned MAX_UNITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beat_tick,
    input  logic       key_in,
    output logic [2:0] length_code,
    output logic       code_valid,
    output logic       overflow,
    output logic       note_active,
    output logic       is_rest
);

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_UNITS);

    note_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       quant_code;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             emit_is_rest;

    length_quantizer #(
        .CNT_W (CNT_W)
    ) u_quant (
        .count_i (cnt_q),
        .code_o  (quant_code)
    );

    assign cnt_inc = {1'b0, cnt_q} + 1'b1;
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef NOTE_LENGTH_REST_EN
    logic rest_q, rest_d;
    // Set once a rest has been force-emitted so the same gap is not counted again.
    logic rest_done_q, rest_done_d;

    assign emit_is_rest = rest_q;
    assign is_rest      = rest_q;
`else
    assign emit_is_rest = 1'b0;
    assign is_rest      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
`ifdef NOTE_LENGTH_REST_EN
        rest_d      = rest_q;
        rest_done_d = rest_done_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef NOTE_LENGTH_REST_EN
                if (key_in) begin
                    cnt_d       = '0;
                    rest_done_d = 1'b0;
                    if (!rest_done_q && (cnt_q != '0)) begin
                        // Report the gap first; the note is measured from the next cycle.
                        code_d  = quant_code;
                        ovf_d   = 1'b0;
                        rest_d  = 1'b1;
                        state_d = StEmit;
                    end else begin
                        state_d = StHold;
                    end
                end else if (beat_tick && !rest_done_q) begin
                    if (cnt_inc == MAX_CNT) begin
                        code_d      = LEN_CODE_U12;
                        ovf_d       = 1'b1;
                        rest_d      = 1'b1;
                        rest_done_d = 1'b1;
                        state_d     = StEmit;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
`else
                if (key_in) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end
`endif
            end
            StHold: begin
                if (!key_in) begin
                    code_d  = quant_code;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StEmit;
`ifdef NOTE_LENGTH_REST_EN
                    rest_d = 1'b0;
`endif
                end else if (beat_tick) begin
                    if (cnt_inc == MAX_CNT) begin
                        code_d  = LEN_CODE_U12;
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StEmit;
`ifdef NOTE_LENGTH_REST_EN
                        rest_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end
            StEmit: begin
                if (emit_is_rest && !ovf_q) begin
                    // Rest emitted on a press: the key is already down, start the note.
                    state_d = StHold;
                end else if (ovf_q && !emit_is_rest && key_in) begin
                    state_d = StWaitRel;
                end else begin
                    state_d = StIdle;
                end
            end
            StWaitRel: begin
                if (!key_in) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef NOTE_LENGTH_REST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rest_q      <= 1'b0;
            rest_done_q <= 1'b0;
        end else begin
            rest_q      <= rest_d;
            rest_done_q <= rest_done_d;
        end
    end
`endif

    assign length_code = code_q;
    assign code_valid  = (state_q == StEmit);
    assign overflow    = (state_q == StEmit) && ovf_q;
    assign note_active = (state_q == StHold);

endmodule

// File: tb/tb_note_length_encoder.sv
module tb_note_length_encoder;

    localparam int MAX_UNITS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       beat_tick;
    logic       key_in;
    logic [2:0] length_code;
    logic       code_valid;
    logic       overflow;
    logic       note_active;
    logic       is_rest;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last emitted code/rest flag and the running rest measurement.
    int exp_code     = 0;
    int exp_is_rest  = 0;
    int rest_cnt     = 0;
    bit rest_done    = 1'b0;

    note_length_encoder #(
        .CNT_W     (5),
        .MAX_UNITS (MAX_UNITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .beat_tick   (beat_tick),
        .key_in      (key_in),
        .length_code (length_code),
        .code_valid  (code_valid),
        .overflow    (overflow),
        .note_active (note_active),
        .is_rest     (is_rest)
    );

    always #5 clk = ~clk;

    // Nearest legal length (ties toward the longer one), then its table code.
    function automatic int ref_code(int n);
        int units [5] = '{1, 2, 3, 4, 12};
        int codes [5] = '{1, 0, 2, 3, 4};
        int best = 0;
        int best_d = 1000;
        for (int i = 0; i < 5; i++) begin
            int d = (n > units[i]) ? n - units[i] : units[i] - n;
            if (d <= best_d) begin
                best_d = d;
                best   = i;
            end
        end
        return codes[best];
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and check outputs just after the edge that samples them.
    task automatic step(input bit k, input bit t, input bit pulse, input int code,
                        input bit ovf, input bit rest, input bit active);
        key_in    = k;
        beat_tick = t;
        @(posedge clk);
        #1;
        if (pulse) begin
            exp_code    = code;
            exp_is_rest = rest;
        end
        check_val("code_valid", code_valid, pulse);
        check_val("overflow", overflow, pulse ? ovf : 1'b0);
        check_val("length_code", length_code, exp_code);
        check_val("is_rest", is_rest, exp_is_rest);
        check_val("note_active", note_active, active);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        key_in    = 1'b0;
        beat_tick = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        exp_code    = 0;
        exp_is_rest = 0;
        rest_cnt    = 0;
        rest_done   = 1'b0;
        check_val("rst_code_valid", code_valid, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_length_code", length_code, 0);
        check_val("rst_is_rest", is_rest, 0);
        check_val("rst_note_active", note_active, 0);
        rst = 1'b0;
    endtask

    // Key released for n cycles; first_is_emit marks a first cycle spent emitting a note.
    task automatic gap(input int n, input int pct, input bit first_is_emit);
        bit t;
        bit pulse;
        for (int i = 0; i < n; i++) begin
            t     = ($urandom_range(0, 99) < pct);
            pulse = 1'b0;
`ifdef NOTE_LENGTH_REST_EN
            if (!(i == 0 && first_is_emit) && !rest_done && t) begin
                rest_cnt++;
                if (rest_cnt == MAX_UNITS) begin
                    pulse     = 1'b1;
                    rest_done = 1'b1;
                end
            end
`endif
            step(1'b0, t, pulse, 4, 1'b1, 1'b1, 1'b0);
            if (pulse && i == n - 1) begin
                step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    // One press: press cycle, hold cycles with random ticks, then release (or reset).
    task automatic note(input int hold, input int pct, input int gap_len, input bit abort);
        bit ovf_taken = 1'b0;
        int cnt = 0;
        bit t;
        bit pulse;
        bit rest_emit = 1'b0;
`ifdef NOTE_LENGTH_REST_EN
        rest_emit = !rest_done && (rest_cnt > 0);
`endif
        step(1'b1, 1'($urandom_range(0, 1)), rest_emit, ref_code(rest_cnt), 1'b0, 1'b1,
             !rest_emit);
        rest_cnt  = 0;
        rest_done = 1'b0;
        if (rest_emit) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < hold; i++) begin
            t     = ($urandom_range(0, 99) < pct);
            pulse = 1'b0;
            if (!ovf_taken && t) begin
                cnt++;
                if (cnt == MAX_UNITS) begin
                    pulse     = 1'b1;
                    ovf_taken = 1'b1;
                end
            end
            step(1'b1, t, pulse, 4, 1'b1, 1'b0, !ovf_taken);
        end
        if (abort) begin
            do_reset();
            gap(gap_len, pct, 1'b0);
        end else begin
            step(1'b0, 1'($urandom_range(0, 1)), !ovf_taken, ref_code(cnt), 1'b0, 1'b0, 1'b0);
            gap(gap_len, pct, !ovf_taken);
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_in    = 1'b0;
        beat_tick = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        gap(3, 0, 1'b0);
        note(3, 100, 3, 1'b0);    // 3 units
        note(0, 100, 3, 1'b0);    // no tick at all
        note(2, 100, 3, 1'b0);    // 2 units
        note(7, 100, 3, 1'b0);    // 7 units
        note(8, 100, 3, 1'b0);    // tie at 8 rounds up
        note(22, 100, 4, 1'b0);   // overflow, keep holding
        note(4, 100, 3, 1'b0);    // normal after overflow
        note(5, 100, 3, 1'b1);    // reset mid-hold
        note(5, 100, 3, 1'b0);
        gap(2, 100, 1'b0);
        note(1, 100, 3, 1'b0);
        gap(30, 100, 1'b0);
        note(3, 100, 3, 1'b0);
        for (int i = 0; i < 80; i++) begin
            note($urandom_range(0, 26), $urandom_range(20, 100), $urandom_range(2, 30), 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
